// File: rtl/packet_rr_allocator.sv
// Output-port allocator for the 5-port mesh router: locks the port to one input
// for a whole packet, rotates priority between packets, gates on downstream credits.
module packet_rr_allocator #(
  parameter int CREDITS = 4,
  parameter int CRW     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     req,
  input  logic [14:0]    flit_id,
  input  logic           credit_in,
  output logic [4:0]     grant,
  output logic [2:0]     sel,
  output logic           xfer,
  output logic [CRW-1:0] credits,
  output logic           busy,
  output logic           timeout_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [2:0] FT_HEAD   = 3'b001;
  localparam logic [2:0] FT_TAIL   = 3'b100;
  localparam logic [2:0] FT_SINGLE = 3'b101;
  localparam logic [2:0] SEL_IDLE  = 3'd7;

  localparam logic [11:0]    WD_LAST  = 12'(TIMEOUT - 1);
  localparam logic [CRW-1:0] CRED_MAX = CRW'(CREDITS);

  logic [0:0]  state;
  logic [2:0]  rr_ptr;
  logic [11:0] wd_cnt;

  logic [4:0] eligible;
  logic [2:0] start;
  logic [9:0] dbl;
  logic [4:0] rot;
  logic [2:0] off;
  logic [3:0] sum;
  logic [2:0] win;
  logic       win_valid;
  logic [2:0] cur_type;
  logic       tail_xfer;
  logic       wd_fire;

  function automatic logic is_head(input logic [2:0] t);
    return (t == FT_HEAD) || (t == FT_SINGLE);
  endfunction

  assign eligible = {req[4] & is_head(flit_id[14:12]),
                     req[3] & is_head(flit_id[11:9]),
                     req[2] & is_head(flit_id[8:6]),
                     req[1] & is_head(flit_id[5:3]),
                     req[0] & is_head(flit_id[2:0])};

  // Rotate the eligible vector so bit 0 is the port just after rr_ptr,
  // pick the lowest set bit, then map the offset back to a port number.
  always_comb begin
    start     = (rr_ptr == 3'd4) ? 3'd0 : rr_ptr + 3'd1;
    dbl       = {eligible, eligible} >> start;
    rot       = dbl[4:0];
    off       = '0;
    win_valid = 1'b0;
    for (int unsigned j = 0; j < 5; j++) begin
      if (!win_valid && rot[j]) begin
        win_valid = 1'b1;
        off       = 3'(j);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    win = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
  end

  always_comb begin
    case (sel)
      3'd0:    cur_type = flit_id[2:0];
      3'd1:    cur_type = flit_id[5:3];
      3'd2:    cur_type = flit_id[8:6];
      3'd3:    cur_type = flit_id[11:9];
      3'd4:    cur_type = flit_id[14:12];
      default: cur_type = '0;
    endcase
  end

  assign busy      = (state == LOCKED);
  assign xfer      = busy && ((req & grant) != '0) && (credits != '0);
  assign tail_xfer = xfer && ((cur_type == FT_TAIL) || (cur_type == FT_SINGLE));
  assign wd_fire   = busy && !xfer && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      sel         <= SEL_IDLE;
      rr_ptr      <= 3'd4;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (win_valid) begin
            state  <= LOCKED;
            grant  <= 5'd1 << win;
            sel    <= win;
            rr_ptr <= win;
          end
        end
        default: begin
          // rr_ptr is left on the released port so it ranks last next round.
          if (tail_xfer || wd_fire) begin
            state       <= IDLE;
            grant       <= '0;
            sel         <= SEL_IDLE;
            wd_cnt      <= '0;
            timeout_err <= wd_fire;
          end else if (xfer) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 12'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRED_MAX;
    end else if (xfer && !credit_in) begin
      credits <= credits - CRW'(1);
    end else if (!xfer && credit_in && (credits != CRED_MAX)) begin
      credits <= credits + CRW'(1);
    end
  end

endmodule
